// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg: shared sizing helper for the register pipeline
package reg_pipe_pkg;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/reg_stage.sv
// reg_stage: one pipeline stage holding a data word and its valid bit
module reg_stage #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             d_v,
  input  logic [WIDTH-1:0] d,
  output logic             q_v,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      q_v <= 1'b0;
      q   <= RST_VAL;
    end else if (en) begin
      q_v <= d_v;
      q   <= d;
    end
  end
endmodule

// File: rtl/reg_pipe.sv
// reg_pipe: DEPTH-stage valid-tagged register pipeline with stall, flush and occupancy count
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [DEPTH*WIDTH-1:0]    tap_data,
  output logic [DEPTH-1:0]          tap_valid,
  output logic [cnt_w(DEPTH)-1:0]   valid_cnt
);
  localparam int CW = cnt_w(DEPTH);
  // chain index 0 is the pipe input, index i+1 is the output of stage i
  logic [DEPTH:0]   cv;
  logic [WIDTH-1:0] cd [DEPTH+1];
  logic [CW-1:0]    cnt_d, cnt_q;
  assign cv[0] = in_valid;
  assign cd[0] = in_data;
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    reg_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_st (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .flush (flush),
      .d_v   (cv[i]),
      .d     (cd[i]),
      .q_v   (cv[i+1]),
      .q     (cd[i+1])
    );
    assign tap_data[i*WIDTH +: WIDTH] = cd[i+1];
  end
  assign tap_valid = cv[DEPTH:1];
  assign out_valid = cv[DEPTH];
  assign out_data  = cd[DEPTH];
  assign valid_cnt = cnt_q;
  always_comb cnt_d = flush ? '0 : en ? cnt_q + CW'(in_valid) - CW'(cv[DEPTH]) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rst) begin
      assert ($countones(tap_valid) == int'(cnt_q));
      assert (int'(cnt_q) <= DEPTH);
    end
  end
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: scoreboard-checked bench for reg_pipe (DEPTH=4) plus a DEPTH=1 instance
module tb_reg_pipe;
  localparam int W = 8, D = 4;
  logic clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic out_valid;
  logic [W-1:0] out_data;
  logic [D*W-1:0] tap_data;
  logic [D-1:0] tap_valid;
  logic [2:0] valid_cnt;
  logic en1 = 1'b0, v1 = 1'b0;
  logic [W-1:0] d1 = '0;
  logic o1_v, t1_v;
  logic [W-1:0] o1_d, t1_d;
  logic [0:0] c1;
  int checks = 0, passed = 0;
  bit mon_on = 1'b0;
  logic [W:0] sb[$];

  reg_pipe #(.WIDTH(W), .DEPTH(D), .RST_VAL('0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_data(out_data), .tap_data(tap_data), .tap_valid(tap_valid),
    .valid_cnt(valid_cnt)
  );

  reg_pipe #(.WIDTH(W), .DEPTH(1), .RST_VAL('0)) u_d1 (
    .clk(clk), .rst(rst), .en(en1), .flush(1'b0), .in_valid(v1), .in_data(d1),
    .out_valid(o1_v), .out_data(o1_d), .tap_data(t1_d), .tap_valid(t1_v), .valid_cnt(c1)
  );

  always #5 clk = ~clk;

  // reference pipe contents, oldest (stage D-1) at the front
  always @(posedge clk) begin
    if (!rst || flush) begin
      sb.delete();
      for (int i = 0; i < D; i++) sb.push_back('0);
    end else if (en) begin
      sb.push_back({in_valid, in_data});
      void'(sb.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [D*W-1:0] et;
    logic [D-1:0] ev;
    int c;
    if (mon_on) begin
      et = '0; ev = '0; c = 0;
      for (int i = 0; i < D; i++) begin
        et[i*W +: W] = sb[D-1-i][W-1:0];
        ev[i] = sb[D-1-i][W];
        c += int'(sb[D-1-i][W]);
      end
      checks++;
      if ({tap_valid, tap_data, out_valid, out_data, valid_cnt} !== {ev, et, ev[D-1], et[D*W-1 -: W], 3'(c)})
        $display("FAIL scoreboard t=%0t got v=%h d=%h ov=%b od=%h cnt=%0d exp v=%h d=%h cnt=%0d",
                 $time, tap_valid, tap_data, out_valid, out_data, valid_cnt, ev, et, c);
      else passed++;
      checks++;
      if ($countones(tap_valid) != int'(valid_cnt))
        $display("FAIL popcount t=%0t got cnt=%0d exp %0d", $time, valid_cnt, $countones(tap_valid));
      else passed++;
    end
  end

  task automatic cyc(input logic e, input logic f, input logic v, input logic [W-1:0] d);
    en = e; flush = f; in_valid = v; in_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      en1 = 1'($urandom); v1 = 1'($urandom); d1 = 8'($urandom);
      cyc(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    end
    checks++;
    if ({out_valid, out_data, valid_cnt, tap_valid, tap_data} !== '0)
      $display("FAIL reset got ov=%b od=%h cnt=%0d tv=%h td=%h exp all 0", out_valid, out_data, valid_cnt, tap_valid, tap_data);
    else passed++;
    checks++;
    if ({o1_v, o1_d, c1} !== '0) $display("FAIL reset_d1 got v=%b d=%h c=%0d exp 0", o1_v, o1_d, c1);
    else passed++;
    en1 = 1'b0;
    rst = 1'b1;
    mon_on = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'hA1 + 8'(i));
      checks++;
      if (valid_cnt !== 3'(i + 1)) $display("FAIL fill_cnt got %0d exp %0d", valid_cnt, i + 1);
      else passed++;
      checks++;
      if (out_valid !== (i == 3)) $display("FAIL fill_ov got %b exp %b", out_valid, (i == 3));
      else passed++;
    end
    checks++;
    if (out_data !== 8'hA1) $display("FAIL fill_od got %h exp a1", out_data);
    else passed++;
  endtask

  task automatic test_stall();
    repeat (5) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      checks++;
      if ({tap_valid, tap_data} !== {4'hF, 32'hA1A2A3A4})
        $display("FAIL stall_taps got %h/%h exp f/a1a2a3a4", tap_valid, tap_data);
      else passed++;
    end
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 8'hA5 + 8'(k));
      checks++;
      if ({out_valid, out_data, valid_cnt} !== {1'b1, 8'hA2 + 8'(k), 3'd4})
        $display("FAIL resume got ov=%b od=%h cnt=%0d exp 1/%h/4", out_valid, out_data, valid_cnt, 8'hA2 + 8'(k));
      else passed++;
    end
  endtask

  task automatic test_bubbles();
    logic [7:0] vin, ov;
    int ec [8];
    vin = 8'b0000_0101;
    ov  = 8'b0010_1000;
    ec  = '{1, 1, 2, 2, 1, 1, 0, 0};
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (valid_cnt !== 3'd0) $display("FAIL drain got cnt=%0d exp 0", valid_cnt);
    else passed++;
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (valid_cnt !== 3'd0) $display("FAIL underflow got cnt=%0d exp 0", valid_cnt);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, vin[i], i < 4 ? 8'(8'h11 * (i + 1)) : 8'h00);
      checks++;
      if (out_valid !== ov[i]) $display("FAIL bubble_ov step %0d got %b exp %b", i, out_valid, ov[i]);
      else passed++;
      checks++;
      if (valid_cnt !== 3'(ec[i])) $display("FAIL bubble_cnt step %0d got %0d exp %0d", i, valid_cnt, ec[i]);
      else passed++;
      if (i >= 3 && i <= 6) begin
        checks++;
        if (out_data !== 8'(8'h11 * (i - 2))) $display("FAIL bubble_od step %0d got %h exp %h", i, out_data, 8'(8'h11 * (i - 2)));
        else passed++;
      end
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1, 8'hB1 + 8'(k));
    checks++;
    if (valid_cnt !== 3'd3) $display("FAIL preflush got cnt=%0d exp 3", valid_cnt);
    else passed++;
    cyc(1'b1, 1'b1, 1'b1, 8'h55);
    checks++;
    if ({valid_cnt, tap_valid, tap_data} !== '0)
      $display("FAIL flush got cnt=%0d tv=%h td=%h exp 0", valid_cnt, tap_valid, tap_data);
    else passed++;
    repeat (4) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00);
      checks++;
      if ({out_valid, out_data, tap_data} !== '0)
        $display("FAIL postflush got ov=%b od=%h td=%h exp 0", out_valid, out_data, tap_data);
      else passed++;
    end
  endtask

  task automatic test_rst_priority();
    en1 = 1'b1; v1 = 1'b1; d1 = 8'h6D;
    cyc(1'b1, 1'b0, 1'b1, 8'hC1);
    cyc(1'b1, 1'b0, 1'b1, 8'hC2);
    rst = 1'b0;
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    rst = 1'b1;
    en1 = 1'b0;
    checks++;
    if ({out_valid, out_data, valid_cnt, tap_valid, tap_data} !== '0)
      $display("FAIL rst_prio got ov=%b od=%h cnt=%0d tv=%h td=%h exp 0", out_valid, out_data, valid_cnt, tap_valid, tap_data);
    else passed++;
    checks++;
    if ({o1_v, o1_d, c1} !== '0) $display("FAIL rst_prio_d1 got v=%b d=%h c=%0d exp 0", o1_v, o1_d, c1);
    else passed++;
  endtask

  task automatic test_depth1();
    en1 = 1'b1; v1 = 1'b1; d1 = 8'h3C;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({o1_v, o1_d, c1, t1_v, t1_d} !== {1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C})
      $display("FAIL d1_load got v=%b d=%h c=%0d exp 1/3c/1", o1_v, o1_d, c1);
    else passed++;
    en1 = 1'b0; v1 = 1'b0; d1 = 8'hC3;
    repeat (2) begin
      cyc(1'b0, 1'b0, 1'b0, 8'h00);
      checks++;
      if ({o1_v, o1_d, c1} !== {1'b1, 8'h3C, 1'b1}) $display("FAIL d1_hold got v=%b d=%h c=%0d exp 1/3c/1", o1_v, o1_d, c1);
      else passed++;
    end
    en1 = 1'b1; v1 = 1'b0; d1 = 8'h5A;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({o1_v, o1_d, c1} !== {1'b0, 8'h5A, 1'b0}) $display("FAIL d1_bubble got v=%b d=%h c=%0d exp 0/5a/0", o1_v, o1_d, c1);
    else passed++;
    v1 = 1'b1; d1 = 8'h96;
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if ({o1_v, o1_d, c1} !== {1'b1, 8'h96, 1'b1}) $display("FAIL d1_next got v=%b d=%h c=%0d exp 1/96/1", o1_v, o1_d, c1);
    else passed++;
    en1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_bubbles();
    test_flush();
    test_rst_priority();
    test_depth1();
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
